// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
// Shared definitions for the input conditioner:
//   rep_state_e - per-button auto-repeat state encoding
//   cnt_width   - bits needed to hold a counter value 0..max_val
//   max_int     - larger of two integers (used to size the repeat counter)
// -----------------------------------------------------------------------------
package input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    // Width of a counter that must represent every value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// -----------------------------------------------------------------------------
// input_conditioner_if
// Bundles the raw inputs and conditioned outputs of the input conditioner.
//   btn_raw/sw_raw/repeat_en : raw pushbuttons, raw switches, repeat enable
//   btn_level/press/release/move, sw_level : conditioned outputs
// Modports:
//   master - drives raw inputs, observes conditioned outputs (game side / bench)
//   slave  - the conditioner itself
// -----------------------------------------------------------------------------
interface input_conditioner_if #(
    parameter int NUM_BTN = 5,
    parameter int NUM_SW  = 16
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_SW-1:0]  sw_raw;
    logic               repeat_en;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_move;
    logic [NUM_SW-1:0]  sw_level;

    modport master (
        output btn_raw, sw_raw, repeat_en,
        input  btn_level, btn_press, btn_release, btn_move, sw_level
    );

    modport slave (
        input  btn_raw, sw_raw, repeat_en,
        output btn_level, btn_press, btn_release, btn_move, sw_level
    );
endinterface

// File: rtl/input_conditioner_debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One input channel: synchroniser, debouncer, registered edge pulses and
// (when HAS_REPEAT=1) a typematic auto-repeat FSM.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   raw_i        : asynchronous raw input
//   rep_ok_i     : auto-repeat permitted this cycle (unused when HAS_REPEAT=0)
//   level_o      : debounced level
//   press_o      : 1-clk pulse in the first cycle level_o reads 1
//   release_o    : 1-clk pulse in the first cycle level_o reads 0
//   move_o       : press pulse plus each auto-repeat tick (0 when HAS_REPEAT=0)
// -----------------------------------------------------------------------------
module debounce_chan
    import input_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3,
    parameter bit HAS_REPEAT      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    input  logic rep_ok_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic move_o
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_s;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   commit_s;

    // Synchroniser shift chain; only the last stage is used downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s_s = sync_q[SYNC_STAGES-1];

    // Debounce: commit only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        commit_s = 1'b0;
        if (s_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s_s;
            cnt_d    = '0;
            commit_s = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Pulses are registered alongside stable_q so they line up with level_o.
        press_d   = commit_s & s_s;
        release_d = commit_s & ~s_s;
    end

    // Debounce state and edge pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    if (HAS_REPEAT) begin : g_rep
        localparam int                RCNT_W      = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
        localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
        localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

        rep_state_e        state_q, state_d;
        logic [RCNT_W-1:0] rcnt_q, rcnt_d;
        logic              move_q, move_d;

        // Repeat FSM state, counter and registered move pulse.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
                rcnt_q  <= '0;
                move_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                move_q  <= move_d;
            end
        end

        // Repeat FSM next state. The FSM follows the debounced edges being
        // committed this cycle so it changes state together with level_o.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            if (release_d) begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (press_d) begin
                            state_d = ST_DELAY;
                            rcnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DELAY: begin
                        if (rcnt_q == DELAY_LAST) begin
                            if (rep_ok_i) begin
                                state_d = ST_REPEAT;
                                rcnt_d  = '0;
                            end else begin
                                // Park at the terminal value until repeat is allowed.
                                rcnt_d = rcnt_q;
                            end
                        end else begin
                            rcnt_d = rcnt_q + RCNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        // Disabled repeat holds the counter at 0 so re-enable
                        // restarts a full period.
                        if (!rep_ok_i) begin
                            rcnt_d = '0;
                        end else if (rcnt_q == PERIOD_LAST) begin
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + RCNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        // Repeat FSM output: a release committing this cycle suppresses any tick.
        always_comb begin
            move_d = 1'b0;
            if (release_d) begin
                move_d = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE:   move_d = press_d;
                    ST_DELAY:  move_d = (rcnt_q == DELAY_LAST) & rep_ok_i;
                    ST_REPEAT: move_d = (rcnt_q == PERIOD_LAST) & rep_ok_i;
                    default:   move_d = 1'b0;
                endcase
            end
        end

        assign move_o = move_q;
    end else begin : g_norep
        logic rep_ok_unused_s;
        assign rep_ok_unused_s = rep_ok_i;
        assign move_o          = 1'b0;
    end

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// N-channel button/switch front end for the maze game. Every pushbutton and
// switch is synchronised and debounced; buttons additionally get press,
// release and auto-repeating move pulses.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : input_conditioner_if.slave
//             in : btn_raw[NUM_BTN], sw_raw[NUM_SW], repeat_en
//             out: btn_level, btn_press, btn_release, btn_move [NUM_BTN],
//                  sw_level[NUM_SW]
// -----------------------------------------------------------------------------
module input_conditioner
    import input_pkg::*;
#(
    parameter int                 NUM_BTN         = 5,
    parameter int                 NUM_SW          = 16,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 1_000_000,
    parameter int                 REPEAT_DELAY    = 50_000_000,
    parameter int                 REPEAT_PERIOD   = 10_000_000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b11110
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input_conditioner_if.slave    bus
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_chk_rdly
        $error("input_conditioner: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_chk_rper
        $error("input_conditioner: REPEAT_PERIOD must be >= 1");
    end

    logic [NUM_BTN-1:0] rep_ok_s;
    logic [NUM_BTN-1:0] btn_level_s, btn_press_s, btn_release_s, btn_move_s;
    logic [NUM_SW-1:0]  sw_level_s;
    logic [NUM_SW-1:0]  sw_press_unused_s, sw_release_unused_s, sw_move_unused_s;

    assign rep_ok_s = {NUM_BTN{bus.repeat_en}} & REPEAT_MASK;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .HAS_REPEAT     (1'b1)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (bus.btn_raw[i]),
            .rep_ok_i (rep_ok_s[i]),
            .level_o  (btn_level_s[i]),
            .press_o  (btn_press_s[i]),
            .release_o(btn_release_s[i]),
            .move_o   (btn_move_s[i])
        );
    end

    for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
        debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .HAS_REPEAT     (1'b0)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (bus.sw_raw[j]),
            .rep_ok_i (1'b0),
            .level_o  (sw_level_s[j]),
            .press_o  (sw_press_unused_s[j]),
            .release_o(sw_release_unused_s[j]),
            .move_o   (sw_move_unused_s[j])
        );
    end

    assign bus.btn_level   = btn_level_s;
    assign bus.btn_press   = btn_press_s;
    assign bus.btn_release = btn_release_s;
    assign bus.btn_move    = btn_move_s;
    assign bus.sw_level    = sw_level_s;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Scoreboard bench: a behavioural model pushes the expected output vector for
// every clock into a queue; a monitor on the falling edge pops and compares.
// Directed sequences cover the named scenarios, then random stimulus follows.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int NB   = 5;
    localparam int NS   = 16;
    localparam int NC   = NB + NS;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam logic [NB-1:0] MASK = 5'b11110;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic [NB-1:0] mov;
        logic [NS-1:0] sw;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    input_conditioner_if #(.NUM_BTN(NB), .NUM_SW(NS)) bus ();

    input_conditioner #(
        .NUM_BTN        (NB),
        .NUM_SW         (NS),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];

    // Reference model state
    logic [NC-1:0]  dly [SYNC];   // raw samples, index 0 is the newest
    logic [DEB-1:0] win [NC];     // last DEB synchronised samples per channel
    logic [NC-1:0]  stab;
    int             mode    [NB];
    longint         press_t [NB];
    longint         anchor  [NB];
    longint         edge_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One model step per clock edge (or asynchronous reset assertion).
    task automatic model_step();
        exp_t          e;
        logic [NC-1:0] s_cur, rise, fall;
        logic [NB-1:0] mv;
        logic          rep;
        longint        c;
        if (!reset_n) begin
            for (int k = 0; k < SYNC; k++) dly[k] = '0;
            for (int ch = 0; ch < NC; ch++) win[ch] = '0;
            stab = '0;
            for (int i = 0; i < NB; i++) mode[i] = M_IDLE;
            exp_q.delete();
            e = '0;
            exp_q.push_back(e);
            return;
        end
        edge_n++;
        c     = edge_n - 1;   // cycle that ends at this edge
        s_cur = dly[SYNC-1];
        rise  = '0;
        fall  = '0;
        for (int ch = 0; ch < NC; ch++) begin
            win[ch] = {win[ch][DEB-2:0], s_cur[ch]};
            if (win[ch] == {DEB{~stab[ch]}}) begin
                stab[ch] = ~stab[ch];
                rise[ch] = stab[ch];
                fall[ch] = ~stab[ch];
            end
        end
        for (int k = SYNC - 1; k > 0; k--) dly[k] = dly[k-1];
        dly[0] = {bus.sw_raw, bus.btn_raw};
        for (int i = 0; i < NB; i++) begin
            rep   = bus.repeat_en & MASK[i];
            mv[i] = 1'b0;
            if (fall[i]) begin
                mode[i] = M_IDLE;
            end else if (rise[i]) begin
                mode[i]    = M_WAIT;
                press_t[i] = edge_n;
                mv[i]      = 1'b1;
            end else if (mode[i] == M_WAIT) begin
                if ((c - press_t[i]) >= RD - 1 && rep) begin
                    mv[i]     = 1'b1;
                    mode[i]   = M_RUN;
                    anchor[i] = edge_n;
                end
            end else if (mode[i] == M_RUN) begin
                if (!rep) begin
                    anchor[i] = edge_n;
                end else if (c - anchor[i] == RP - 1) begin
                    mv[i]     = 1'b1;
                    anchor[i] = edge_n;
                end
            end
        end
        e.lvl = stab[NB-1:0];
        e.prs = rise[NB-1:0];
        e.rel = fall[NB-1:0];
        e.mov = mv;
        e.sw  = stab[NC-1:NB];
        exp_q.push_back(e);
    endtask

    // Model process
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            model_step();
        end
    end

    // Monitor: compare DUT outputs once per cycle away from the active edge.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_move, bus.sw_level};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty at %0t: no expected entry", $time);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL sb_cycle at %0t: lvl %b/%b prs %b/%b rel %b/%b mov %b/%b sw %h/%h (got/expected)",
                             $time, got.lvl, e.lvl, got.prs, e.prs, got.rel, e.rel,
                             got.mov, e.mov, got.sw, e.sw);
                end
            end
        end
    end

    // Directed and random stimulus
    initial begin
        int            cnt;
        logic          acc;
        logic [29:0]   got_mv, exp_mv;

        bus.btn_raw   = '0;
        bus.sw_raw    = '0;
        bus.repeat_en = 1'b1;
        tick(3);
        check("reset_state",
              64'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_move, bus.sw_level}), 64'd0);
        reset_n = 1'b1;
        tick(2);

        // Single press on button 0 (no repeat) and its latency
        bus.btn_raw[0] = 1'b1;
        tick(5);
        check("t1_level_early", 64'(bus.btn_level[0]), 64'd0);
        tick(1);
        check("t1_level", 64'(bus.btn_level[0]), 64'd1);
        check("t1_press", 64'(bus.btn_press[0]), 64'd1);
        check("t1_move", 64'(bus.btn_move[0]), 64'd1);
        check("t1_no_release", 64'(bus.btn_release[0]), 64'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            cnt += int'(bus.btn_move[0]);
            tick(1);
        end
        check("t4_single_move", 64'(cnt), 64'd1);
        bus.btn_raw[0] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            cnt += int'(bus.btn_release[0]);
        end
        check("t1_release_once", 64'(cnt), 64'd1);

        // Short glitch on button 1 is discarded
        bus.btn_raw[1] = 1'b1;
        tick(3);
        bus.btn_raw[1] = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            acc |= bus.btn_level[1] | bus.btn_press[1] | bus.btn_move[1];
            tick(1);
        end
        check("t2_glitch", 64'(acc), 64'd0);

        // Auto-repeat timing on button 1
        exp_mv = '0;
        exp_mv[0] = 1'b1;
        for (int k = RD; k < 30; k += RP) exp_mv[k] = 1'b1;
        bus.btn_raw[1] = 1'b1;
        tick(6);
        for (int k = 0; k < 30; k++) begin
            got_mv[k] = bus.btn_move[1];
            tick(1);
        end
        check("t3_repeat_ticks", 64'(got_mv), 64'(exp_mv));
        bus.btn_raw[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            cnt += int'(bus.btn_release[1]);
        end
        check("t3_release_once", 64'(cnt), 64'd1);

        // Repeat enable dropped and restored during REPEAT
        bus.sw_raw = 16'h00FF;
        exp_mv = '0;
        exp_mv[0]  = 1'b1;
        exp_mv[10] = 1'b1;
        exp_mv[13] = 1'b1;
        exp_mv[23] = 1'b1;
        exp_mv[26] = 1'b1;
        exp_mv[29] = 1'b1;
        bus.btn_raw[1] = 1'b1;
        tick(6);
        for (int k = 0; k < 30; k++) begin
            got_mv[k] = bus.btn_move[1];
            if (k == 14) bus.repeat_en = 1'b0;
            if (k == 20) bus.repeat_en = 1'b1;
            tick(1);
        end
        check("t5_enable_gap", 64'(got_mv), 64'(exp_mv));
        check("t5_sw_level", 64'(bus.sw_level), 64'h00FF);

        // Reset in the middle of REPEAT, button still held
        reset_n = 1'b0;
        #1;
        check("t6_reset_outputs",
              64'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_move, bus.sw_level}), 64'd0);
        tick(2);
        reset_n    = 1'b1;
        bus.sw_raw = 16'hA5A5;
        tick(5);
        check("t6_press_early", 64'(bus.btn_press[1]), 64'd0);
        check("t6_sw_early", 64'(bus.sw_level), 64'd0);
        tick(1);
        check("t6_press_after_reset", 64'(bus.btn_press[1]), 64'd1);
        check("t6_move_after_reset", 64'(bus.btn_move[1]), 64'd1);
        check("t6_sw_level", 64'(bus.sw_level), 64'hA5A5);

        // Random stimulus against the scoreboard
        for (int k = 0; k < 600; k++) begin
            if (k == 300) begin
                reset_n = 1'b0;
                tick(2);
                reset_n = 1'b1;
            end
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 11) == 0) bus.btn_raw[b] = ~bus.btn_raw[b];
            for (int s = 0; s < NS; s++)
                if ($urandom_range(0, 15) == 0) bus.sw_raw[s] = ~bus.sw_raw[s];
            if ($urandom_range(0, 19) == 0) bus.repeat_en = ~bus.repeat_en;
            tick(1);
        end
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
